// File: rtl/mmio_led_bank_if.sv
// Data-memory bus slice seen by the LED bank.
// The CPU side drives address/write; the bank answers with hit/read data.
interface mmio_led_bank_if;
    logic [31:0] rw_addr;
    logic [31:0] w_data;
    logic        w_en;
    logic [31:0] r_data;
    logic        hit;

    modport master (
        output rw_addr,
        output w_data,
        output w_en,
        input  r_data,
        input  hit
    );

    modport slave (
        input  rw_addr,
        input  w_data,
        input  w_en,
        output r_data,
        output hit
    );
endinterface

// File: rtl/mmio_led_bank.sv
// Memory-mapped multi-channel LED controller with a programmable tick.
// Channels run static, blink or rotate patterns for a tick-counted duration.
module mmio_led_bank #(
    parameter logic [31:0]      BASE_ADDR = 32'h0000_03c0,
    parameter int               N_CH      = 4,
    parameter int               LED_W     = 8,
    parameter int               DIV_W     = 24,
    parameter logic [DIV_W-1:0] DIV_RESET = 24'h0004b0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    mmio_led_bank_if.slave          bus,
    output logic                    tick,
    output logic [N_CH*LED_W-1:0]   led_out
);

    logic [31:0]       off;
    logic [3:0]        widx;
    logic              in_win;
    logic              sel_ctrl;
    logic              sel_div;
    logic              sel_stat;
    logic [N_CH-1:0]   sel_ch;
    logic              hit_c;
    logic              wr_ctrl;
    logic              wr_div;
    logic [N_CH-1:0]   wr_ch;
    logic [N_CH-1:0]   busy;
    logic [31:0]       rd;
    logic              unused_bits;

    logic              en_q, en_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;

    logic [LED_W-1:0]  pat_q   [N_CH];
    logic [LED_W-1:0]  pat_d   [N_CH];
    logic [7:0]        dur_q   [N_CH];
    logic [7:0]        dur_d   [N_CH];
    logic [1:0]        mode_q  [N_CH];
    logic [1:0]        mode_d  [N_CH];
    logic              phase_q [N_CH];
    logic              phase_d [N_CH];

    // Modular subtraction makes addresses below the base land far outside.
    assign off    = bus.rw_addr - BASE_ADDR;
    assign in_win = (off[31:6] == 26'd0);
    assign widx   = off[5:2];

    assign unused_bits = ^{off[1:0], bus.w_data};

    // Window decode: which register, if any, the address selects.
    always_comb begin
        sel_ctrl = in_win && (widx == 4'd0);
        sel_div  = in_win && (widx == 4'd1);
        sel_stat = in_win && (widx == 4'd2);
        sel_ch   = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_ch[i] = in_win && (widx == 4'(i + 4));
        end
        hit_c   = sel_ctrl | sel_div | sel_stat | (|sel_ch);
        wr_ctrl = bus.w_en && sel_ctrl;
        wr_div  = bus.w_en && sel_div;
        wr_ch   = bus.w_en ? sel_ch : '0;
    end

    assign bus.hit = hit_c;
    assign tick    = en_q && (cnt_q == div_q);

    // Tick counter: restarts on DIV write, on each tick and while disabled.
    always_comb begin
        en_d  = wr_ctrl ? bus.w_data[0] : en_q;
        div_d = wr_div ? bus.w_data[DIV_W-1:0] : div_q;
        cnt_d = (wr_div || !en_q || tick) ? '0 : cnt_q + 1'b1;
    end

    // Control registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q  <= 1'b1;
            div_q <= DIV_RESET;
            cnt_q <= '0;
        end else begin
            en_q  <= en_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // Channel next state: a bus write beats a same-edge tick.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pat_d[i]   = pat_q[i];
            dur_d[i]   = dur_q[i];
            mode_d[i]  = mode_q[i];
            phase_d[i] = phase_q[i];
            if (wr_ch[i]) begin
                pat_d[i]   = bus.w_data[LED_W-1:0];
                dur_d[i]   = bus.w_data[23:16];
                mode_d[i]  = bus.w_data[25:24];
                phase_d[i] = 1'b0;
            end else if (tick) begin
                if (dur_q[i] == 8'd1) begin
                    pat_d[i]   = '0;
                    dur_d[i]   = '0;
                    mode_d[i]  = '0;
                    phase_d[i] = 1'b0;
                end else begin
                    if (mode_q[i] == 2'd1) begin
                        phase_d[i] = ~phase_q[i];
                    end
                    if (mode_q[i] == 2'd2) begin
                        pat_d[i] = (pat_q[i] << 1) | (pat_q[i] >> (LED_W - 1));
                    end
                    if (dur_q[i] != 8'd0) begin
                        dur_d[i] = dur_q[i] - 8'd1;
                    end
                end
            end
        end
    end

    // Channel registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= '{default: '0};
            dur_q   <= '{default: '0};
            mode_q  <= '{default: '0};
            phase_q <= '{default: 1'b0};
        end else begin
            pat_q   <= pat_d;
            dur_q   <= dur_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
        end
    end

    // LED drive and busy flags straight from registers.
    always_comb begin
        led_out = '0;
        busy    = '0;
        for (int i = 0; i < N_CH; i++) begin
            led_out[i*LED_W +: LED_W] = phase_q[i] ? '0 : pat_q[i];
            busy[i] = (dur_q[i] != 8'd0);
        end
    end

    // Read mux; zero whenever the address is not a mapped register.
    always_comb begin
        rd = '0;
        unique case (1'b1)
            sel_ctrl: rd[0] = en_q;
            sel_div:  rd[DIV_W-1:0] = div_q;
            sel_stat: rd[N_CH-1:0] = busy;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (sel_ch[i]) begin
                        rd[LED_W-1:0] = pat_q[i];
                        rd[23:16]     = dur_q[i];
                        rd[25:24]     = mode_q[i];
                        rd[31]        = phase_q[i];
                    end
                end
            end
        endcase
    end

    assign bus.r_data = rd;

endmodule

// File: doc/mmio_led_bank.md
# mmio_led_bank

Memory-mapped, parametrised multi-channel LED output controller with an internal programmable tick generator. It sits on the CPU data-memory bus next to `data_mem`. It decodes its own address window and drives `N_CH` independent LED channels. Each channel supports static, blink and rotate modes with an optional tick-counted duration. It replaces the hard-wired single LED port, its fixed write/status addresses and the fixed clock divider.

## Interface
- `BASE_ADDR`, 32'h0000_03c0: word-aligned base of the 64-byte register window.
- `N_CH`, 4: number of LED channels, 1..8.
- `LED_W`, 8: bits per channel, 1..16.
- `DIV_W`, 24: width of the tick divisor.
- `DIV_RESET`, 24'h0004b0: divisor value after reset.

Ports:
- `clock` in 1: single system clock; all state on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rw_addr` in 32: bus byte address; `[1:0]` ignored.
- `w_data` in 32: bus write data.
- `w_en` in 1: bus write strobe, one cycle per write.
- `r_data` out 32: combinational read data; 0 when `hit`=0.
- `hit` out 1: combinational; 1 when `rw_addr` lies in `[BASE_ADDR, BASE_ADDR+0x3f]` and the offset is mapped; parent muxes `r_data` on it.
- `tick` out 1: one-cycle tick strobe.
- `led_out` out `N_CH*LED_W`: channel i occupies bits `[i*LED_W +: LED_W]`.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00 CTRL, RW: bit0 = EN.
  - 0x04 DIV, RW: `[DIV_W-1:0]`.
  - 0x08 STATUS, RO: bit i = BUSY[i].
  - 0x10+4*i CH[i], RW, for i < `N_CH`.
- Unmapped offsets: `hit`=0, `r_data`=0, writes ignored. Writes to STATUS are ignored, but `hit`=1.
- Tick generator:
  - `cnt` counts 0..DIV; `tick` = EN && (`cnt`==DIV), combinational from registers.
  - On tick, `cnt`←0; otherwise `cnt`←`cnt`+1.
  - EN=0 holds `cnt` at 0.
  - DIV=0 gives a tick every cycle while EN=1.
  - A DIV write forces `cnt`←0 on that edge; no tick is taken from the old value.
- CH[i] write fields:
  - `[LED_W-1:0]` PAT.
  - `[23:16]` DUR, in ticks.
  - `[25:24]` MODE: 0 static, 1 blink, 2 rotate-left, 3 treated as static.
  - A write loads PAT, DUR and MODE, and clears PHASE.
- Per channel, on a tick edge (no write to that channel on the same edge):
  - MODE 1: PHASE toggles.
  - MODE 2: PAT rotates left 1 within `LED_W` (MSB→LSB).
  - If DUR>1: DUR−1.
  - If DUR==1: DUR←0, PAT←0, MODE←0, PHASE←0; the channel is finished.
  - DUR==0 before the tick: unlimited; the mode keeps animating and DUR stays 0.
- Output and status:
  - `led_out` channel = PHASE ? 0 : PAT, from registers.
  - BUSY[i] = (DUR≠0).
- CH[i] read returns: current PAT in `[LED_W-1:0]`, DUR in `[23:16]`, MODE in `[25:24]`, PHASE in bit 31, zeros elsewhere.

## Timing
- Reset (async assert, sync-safe release): EN=1, DIV=`DIV_RESET`, `cnt`=0, all PAT/DUR/MODE/PHASE=0. So `led_out`=0, `tick`=0 (EN=1 but `cnt`≠DIV unless DIV_RESET=0), STATUS=0.
- Write latency: a write sampled on edge k is visible on `led_out`/`r_data` after edge k.
- A write to CH[i] on the same edge as a tick: the write wins; that channel ignores the tick. Other channels process the tick.
- Rewriting a busy channel restarts it with the new fields.
- EN cleared mid-operation: channels freeze, holding PAT/DUR/PHASE. Setting EN again resumes with `cnt` from 0.
- Reset mid-operation: immediate clear of all state, regardless of `clock`.
- Tick period is DIV+1 cycles; the first tick after reset or a DIV write comes DIV cycles after the enabling edge.

## Test plan
- Reset:
  - Stimulus: assert `reset_n`=0 mid-run, then release.
  - Required: `led_out`=0; STATUS reads 0; DIV reads 0x4b0; CTRL reads 1; `hit`=0 at addr 0x3bc and 0x400.
- Static with duration:
  - Stimulus: DIV←3, CH0←0x0002_00A5.
  - Required: `led_out[7:0]`=0xA5 and BUSY0=1 for 2 ticks (period 4 cycles); after the 2nd tick, `led_out[7:0]`=0 and BUSY0=0.
- Rotate, unlimited:
  - Stimulus: DIV←0, CH1←0x0200_0081.
  - Required: channel 1 sequence 0x81, 0x03, 0x06, 0x0C on successive cycles; BUSY1 stays 0.
- Blink:
  - Stimulus: DIV←1, CH2←0x0104_00FF.
  - Required: channel 2 = FF, 00, FF, 00 with each state lasting 2 cycles; after 4 ticks, 0 and BUSY2=0.
- Collision:
  - Stimulus: write CH0←0x0003_0011 on a tick edge while CH1 is rotating.
  - Required: CH0 reads DUR=3 (not 2); CH1 still rotates on that edge.
- Disable/resume:
  - Stimulus: CTRL←0 mid-blink, wait 20 cycles, then CTRL←1.
  - Required: `tick`=0 and `led_out`/DUR frozen while disabled; the first tick comes DIV cycles after re-enable.
